// File: rtl/asu_sched_pkg.sv
// Shared constants, state encoding and the round-robin grant rule for asu_sched.
// Fixed-priority arbitration is selected with ASU_SCHED_FIXED_PRIO_EN.
package asu_sched_pkg;

    localparam int ASU_W = 8;
    localparam int RSP_W = ASU_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // One-hot grant for two requesters; on contention the one not served last wins.
    function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic last_grant);
        logic [1:0] grant;
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/asu_rr_arb.sv
// Two-way request arbiter for asu_sched: round-robin by default, fixed priority
// (requester 0 first) when ASU_SCHED_FIXED_PRIO_EN is defined.
module asu_rr_arb
    import asu_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid_i,
    input  logic       enable_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

`ifdef ASU_SCHED_FIXED_PRIO_EN

    logic unused_arb;
    assign unused_arb = ^{clk, reset, accept_i};

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (req_valid_i[0]) begin
                grant_o = 2'b01;
            end else if (req_valid_i[1]) begin
                grant_o = 2'b10;
            end
        end
    end

`else

    logic last_grant_q;

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            grant_o = rr_grant(req_valid_i, last_grant_q);
        end
    end

    // Reset to 1 so requester 0 wins the first contended grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (accept_i) begin
            last_grant_q <= grant_o[1];
        end
    end

`endif

endmodule

// File: rtl/asu_sched.sv
// Two-requester scheduler for one shared external ASU: arbitrate, register operands,
// capture {carry, out} a cycle later and return it on a valid/ready port (macro: ASU_SCHED_FIXED_PRIO_EN).
module asu_sched
    import asu_sched_pkg::*;
#(
    parameter int W = ASU_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_mode,
    input  logic [2*W-1:0]   req_x,
    input  logic [2*W-1:0]   req_y,
    output logic             asu_mode,
    output logic [W-1:0]     asu_x,
    output logic [W-1:0]     asu_y,
    input  logic             asu_carry,
    input  logic [W-1:0]     asu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W:0]       rsp_data
);

    state_e         state_q;
    logic           asu_mode_q;
    logic [W-1:0]   asu_x_q;
    logic [W-1:0]   asu_y_q;
    logic           rsp_valid_q;
    logic           rsp_id_q;
    logic [W:0]     rsp_data_q;

    logic [1:0]     grant;
    logic           accept;
    logic           sel;
    logic           sel_mode;
    logic [W-1:0]   sel_x;
    logic [W-1:0]   sel_y;

    asu_rr_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .enable_i    (state_q == IDLE),
        .accept_i    (accept),
        .grant_o     (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign sel       = grant[1];
    assign sel_mode  = sel ? req_mode[1]      : req_mode[0];
    assign sel_x     = sel ? req_x[2*W-1:W]   : req_x[W-1:0];
    assign sel_y     = sel ? req_y[2*W-1:W]   : req_y[W-1:0];

    // NOTE: sequential state uses non-blocking assignments and an async reset branch first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            asu_mode_q  <= 1'b0;
            asu_x_q     <= '0;
            asu_y_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        asu_mode_q <= sel_mode;
                        asu_x_q    <= sel_x;
                        asu_y_q    <= sel_y;
                        rsp_id_q   <= sel;
                        state_q    <= ISSUE;
                    end
                end
                // The ASU has had a full cycle on the registered operands.
                ISSUE: begin
                    rsp_data_q  <= {asu_carry, asu_out};
                    rsp_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign asu_mode  = asu_mode_q;
    assign asu_x     = asu_x_q;
    assign asu_y     = asu_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_asu_sched.sv
// Self-checking bench for asu_sched with a behavioural asu_gate stand-in
// (mode 0: x+y, mode 1: x << y[2:0], 9-bit {carry, out}).
module tb_asu_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_mode;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic        asu_mode;
    logic [7:0]  asu_x;
    logic [7:0]  asu_y;
    logic        asu_carry;
    logic [7:0]  asu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [8:0]  rsp_data;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last = 1;

    always #10 clk = ~clk;

    asu_sched #(.W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_x     (req_x),
        .req_y     (req_y),
        .asu_mode  (asu_mode),
        .asu_x     (asu_x),
        .asu_y     (asu_y),
        .asu_carry (asu_carry),
        .asu_out   (asu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    function automatic logic [8:0] asu_ref(input logic m, input logic [7:0] x, input logic [7:0] y);
        if (!m) return {1'b0, x} + {1'b0, y};
        return {1'b0, x} << y[2:0];
    endfunction

    assign {asu_carry, asu_out} = asu_ref(asu_mode, asu_x, asu_y);

    // Winner for the given valids, or -1 when nobody is asking.
    function automatic int model_grant(input logic [1:0] v);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ASU_SCHED_FIXED_PRIO_EN
        return 0;
`else
        return (model_last == 0) ? 1 : 0;
`endif
    endfunction

    task automatic do_op(input int r, input logic m, input logic [7:0] x, input logic [7:0] y,
                         output logic id, output logic [8:0] d, output bit to);
        to = 1'b1;
        id = 1'b0;
        d  = '0;
        @(posedge clk); #1;
        req_mode[r] = m;
        req_x[r*8 +: 8] = x;
        req_y[r*8 +: 8] = y;
        req_valid[r] = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                to = 1'b0;
                break;
            end
        end
        if (to) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        model_last = r;
        to = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                id = rsp_id;
                d  = rsp_data;
                to = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        req_mode = 2'b00;
        req_x = '0;
        req_y = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        n_checks++; if (asu_mode !== 1'b0) begin n_fail++; $display("FAIL reset_asu_mode: got %b expected 0", asu_mode); end
        n_checks++; if (asu_x !== 8'h00) begin n_fail++; $display("FAIL reset_asu_x: got %h expected 00", asu_x); end
        n_checks++; if (asu_y !== 8'h00) begin n_fail++; $display("FAIL reset_asu_y: got %h expected 00", asu_y); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
        n_checks++; if (rsp_data !== 9'h000) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 000", rsp_data); end
        @(negedge clk);
        reset = 1'b0;
        model_last = 1;
    endtask

    task automatic test_single_op();
        @(posedge clk); #1;
        req_mode[0] = 1'b0;
        req_x[7:0] = 8'hF0;
        req_y[7:0] = 8'h20;
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        model_last = 0;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL single_ready_issue: got %b expected 00", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", rsp_valid); end
        n_checks++; if ({asu_mode, asu_x, asu_y} !== {1'b0, 8'hF0, 8'h20}) begin
            n_fail++; $display("FAIL single_operands: got %b %h %h expected 0 f0 20", asu_mode, asu_x, asu_y);
        end
        @(posedge clk); @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_rsp_id: got %b expected 0", rsp_id); end
        n_checks++; if (rsp_data !== 9'h110) begin n_fail++; $display("FAIL single_rsp_data: got %h expected 110", rsp_data); end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_clear: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        logic [8:0] exp0;
        logic [8:0] exp1;
        exp0 = asu_ref(1'b1, 8'h81, 8'h03);
        exp1 = asu_ref(1'b0, 8'h7F, 8'h01);
        @(posedge clk); #1;
        req_mode[0] = 1'b1; req_x[7:0] = 8'h81; req_y[7:0] = 8'h03;
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant0: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        model_last = 0;
        req_mode[1] = 1'b0; req_x[15:8] = 8'h7F; req_y[15:8] = 8'h01;
        req_valid = 2'b10;
        @(posedge clk); @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, exp0}) begin
            n_fail++; $display("FAIL bp_first_rsp: got %b %b %h expected 1 0 %h", rsp_valid, rsp_id, rsp_data, exp0);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 1'b0, exp0, 2'b00}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b id=%b data=%h ready=%b expected 1 0 %h 00",
                         c, rsp_valid, rsp_id, rsp_data, req_ready, exp0);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_pre_accept: got %b expected 1", rsp_valid); end
        @(posedge clk); @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got %b expected 0", rsp_valid); end
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        model_last = 1;
        @(posedge clk); @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, exp1}) begin
            n_fail++; $display("FAIL bp_second_rsp: got %b %b %h expected 1 1 %h", rsp_valid, rsp_id, rsp_data, exp1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_pattern_sweep();
        logic       m_tab [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] x_tab [10] = '{8'hFF, 8'h01, 8'h00, 8'hFF, 8'h80, 8'hA5, 8'h3C, 8'h7E, 8'h55, 8'hC3};
        logic [7:0] y_tab [10] = '{8'h01, 8'h07, 8'h00, 8'h01, 8'h80, 8'h04, 8'hC4, 8'h00, 8'hAA, 8'h02};
        logic       id;
        logic [8:0] d;
        logic [8:0] exp;
        bit         to;
        for (int i = 0; i < 10; i++) begin
            do_op(i % 2, m_tab[i], x_tab[i], y_tab[i], id, d, to);
            exp = asu_ref(m_tab[i], x_tab[i], y_tab[i]);
            n_checks++;
            if (to || id !== 1'(i % 2) || d !== exp) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got timeout=%0d id=%b data=%h expected id=%0d data=%h", i, to, id, d, i % 2, exp);
            end
        end
    endtask

    task automatic test_random(input int n_rsp, input bit both, input bit rdy_always, input string name);
        logic       exp_id_q [$];
        logic [8:0] exp_data_q [$];
        logic [1:0] exp_rdy;
        logic       eid;
        logic [8:0] edata;
        int         got = 0;
        int         acc = -1;
        int         g;
        for (int cyc = 0; cyc < 600 && got < n_rsp; cyc++) begin
            @(posedge clk); #1;
            if (acc >= 0) begin
                req_mode[acc] = 1'($urandom_range(0, 1));
                req_x[acc*8 +: 8] = 8'($urandom);
                req_y[acc*8 +: 8] = 8'($urandom);
                req_valid[acc] = both ? 1'b1 : 1'($urandom_range(0, 1));
                acc = -1;
            end
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && (both || $urandom_range(0, 2) == 0)) begin
                    req_mode[r] = 1'($urandom_range(0, 1));
                    req_x[r*8 +: 8] = 8'($urandom);
                    req_y[r*8 +: 8] = 8'($urandom);
                    req_valid[r] = 1'b1;
                end
            end
            rsp_ready = rdy_always ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            g = (exp_id_q.size() != 0) ? -1 : model_grant(req_valid);
            exp_rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
            n_checks++;
            if (req_ready !== exp_rdy) begin
                n_fail++; $display("FAIL %s_ready cyc %0d: got %b expected %b", name, cyc, req_ready, exp_rdy);
            end
            if (g >= 0) begin
                exp_id_q.push_back(1'(g));
                exp_data_q.push_back(asu_ref(req_mode[g], req_x[g*8 +: 8], req_y[g*8 +: 8]));
                acc = g;
                model_last = g;
            end else if (rsp_valid) begin
                if (exp_id_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL %s_spurious_rsp cyc %0d: got valid=1 expected 0", name, cyc);
                end else if (rsp_ready) begin
                    eid = exp_id_q.pop_front();
                    edata = exp_data_q.pop_front();
                    got++;
                    n_checks++;
                    if (rsp_id !== eid || rsp_data !== edata) begin
                        n_fail++;
                        $display("FAIL %s_rsp[%0d]: got id=%b data=%h expected id=%b data=%h", name, got, rsp_id, rsp_data, eid, edata);
                    end
                end
            end
        end
        n_checks++;
        if (got < n_rsp) begin
            n_fail++; $display("FAIL %s_timeout: got %0d responses expected %0d", name, got, n_rsp);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        logic       id;
        logic [8:0] d;
        bit         to;
        do_op(0, 1'b0, 8'h11, 8'h22, id, d, to);
        @(posedge clk); #1;
        req_mode[1] = 1'b1; req_x[15:8] = 8'h0F; req_y[15:8] = 8'h01;
        req_valid = 2'b10;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, asu_mode, asu_x, asu_y, rsp_valid, rsp_id, rsp_data} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready=%b mode=%b x=%h y=%h valid=%b id=%b data=%h expected all 0",
                     req_ready, asu_mode, asu_x, asu_y, rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        reset = 1'b0;
        model_last = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_rsp[%0d]: got %b expected 0", c, rsp_valid); end
        end
        @(posedge clk); #1;
        req_mode = 2'b00;
        req_x = {8'h40, 8'h05};
        req_y = {8'h40, 8'h06};
        req_valid = 2'b11;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midreset_grant: got %b expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        model_last = 0;
        @(posedge clk); @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 9'h00B}) begin
            n_fail++; $display("FAIL midreset_rsp: got %b %b %h expected 1 0 00b", rsp_valid, rsp_id, rsp_data);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_pattern_sweep();
        test_random(8, 1'b1, 1'b1, "contention");
        test_random(20, 1'b0, 1'b0, "mixed");
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
